// File: rtl/muldiv_share_arb_pkg.sv
// Shared types for the mul/div sharing arbiter.
//   riscv      : XLEN
//   ariane_pkg : fu_op / fu_data_t, TRANS_ID_BITS, the ownership-table entry
//                type and the mul/div op classifiers that the unit and the
//                arbiter both use.
package riscv;
    localparam int XLEN = 64;
endpackage

package ariane_pkg;
    localparam int TRANS_ID_BITS = 3;

    typedef enum logic [3:0] {
        ADD, MUL, MULH, MULHU, MULHSU, MULW,
        DIV, DIVU, DIVW, DIVUW, REM, REMU, REMW, REMUW
    } fu_op;

    typedef struct packed {
        fu_op                     operator;
        logic [riscv::XLEN-1:0]   operand_a;
        logic [riscv::XLEN-1:0]   operand_b;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } fu_data_t;

    // owner is 2 bits wide: enough for up to 4 requesters
    typedef struct packed {
        logic                     valid;
        logic [1:0]               owner;
        logic [TRANS_ID_BITS-1:0] orig_id;
    } muldiv_tag_entry_t;

    function automatic logic is_mul_op(fu_op op);
        return op inside {MUL, MULH, MULHU, MULHSU, MULW};
    endfunction

    function automatic logic is_div_op(fu_op op);
        return op inside {DIV, DIVU, DIVW, DIVUW, REM, REMU, REMW, REMUW};
    endfunction
endpackage

// File: rtl/muldiv_share_arb_if.sv
// Bundle between requesters / shared mul-div unit and the arbiter.
//   slave  : arbiter view (requests + unit results in, issue + responses out)
//   master : environment view (the inverse)
interface muldiv_share_arb_if
    import ariane_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = TRANS_ID_BITS
) ();
    logic [NUM_REQ-1:0]               req_valid_i;
    fu_data_t [NUM_REQ-1:0]           req_data_i;
    logic [NUM_REQ-1:0]               req_ready_o;
    logic                             fu_valid_o;
    fu_data_t                         fu_data_o;
    logic                             fu_ready_i;
    logic                             fu_res_valid_i;
    logic [TAG_W-1:0]                 fu_res_tag_i;
    logic [riscv::XLEN-1:0]           fu_result_i;
    logic [NUM_REQ-1:0]               rsp_valid_o;
    logic [TAG_W-1:0]                 rsp_trans_id_o;
    logic [riscv::XLEN-1:0]           rsp_result_o;
    logic                             busy_o;
    logic                             dbg_bad_tag_o;   // sticky: result seen on an invalid tag

    modport slave (
        input  req_valid_i, req_data_i, fu_ready_i, fu_res_valid_i, fu_res_tag_i, fu_result_i,
        output req_ready_o, fu_valid_o, fu_data_o, rsp_valid_o, rsp_trans_id_o, rsp_result_o,
               busy_o, dbg_bad_tag_o
    );
    modport master (
        output req_valid_i, req_data_i, fu_ready_i, fu_res_valid_i, fu_res_tag_i, fu_result_i,
        input  req_ready_o, fu_valid_o, fu_data_o, rsp_valid_o, rsp_trans_id_o, rsp_result_o,
               busy_o, dbg_bad_tag_o
    );
endinterface

// File: rtl/muldiv_share_arb_rr_arb_ptr.sv
// rr_arb_ptr: round-robin priority select with its own pointer register.
//   req       : request vector
//   gnt       : one-hot grant (combinational)
//   gnt_idx   : index of the granted request
//   gnt_valid : any request granted; pointer advances past the winner only then
module rr_arb_ptr #(
    parameter  int N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);
    logic [IDX_W-1:0] ptr_q, ptr_d, idx;

    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = IDX_W'((int'(ptr_q) + k) % N);
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
        gnt = '0;
        if (gnt_valid) gnt[gnt_idx] = 1'b1;
        ptr_d = ptr_q;
        if (gnt_valid) ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end
endmodule

// File: rtl/muldiv_share_arb.sv
// muldiv_share_arb: shares one mul/div unit between NUM_REQ requesters.
//   clk_i, rst_ni : clock, async active-low reset
//   flush_i       : clears the ownership table, then holds issue off for QUIET_CYCLES
//   bus (slave)   : requester ops/ready, unit issue/results, routed responses, busy
// Each issued op gets a unit-local tag (lowest free table entry); the entry
// remembers owner and original trans_id so out-of-order results are routed back.
module muldiv_share_arb
    import ariane_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int TAG_W        = TRANS_ID_BITS,
    parameter int QUIET_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    muldiv_share_arb_if.slave bus
);
    localparam int DEPTH = 2 ** TAG_W;
    localparam int QW    = $clog2(QUIET_CYCLES + 1);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    muldiv_tag_entry_t  table_q [DEPTH];
    muldiv_tag_entry_t  res_entry;
    logic [QW-1:0]      quiet_q;
    logic               bad_tag_q;
    logic [TAG_W-1:0]   alloc_tag;
    logic               tag_free;
    logic [NUM_REQ-1:0] elig, gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid, res_hit;
    fu_data_t           fu_data;

    // Allocator looks at registered state only: a tag freed this cycle is
    // not reusable until next cycle. Descending scan leaves the lowest free.
    always_comb begin
        alloc_tag = '0;
        tag_free  = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!table_q[i].valid) begin
                tag_free  = 1'b1;
                alloc_tag = TAG_W'(i);
            end
        end
    end

    // Division only issues when the serial divider can take it.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = bus.req_valid_i[i]
                    && (is_mul_op(bus.req_data_i[i].operator)
                        || (is_div_op(bus.req_data_i[i].operator) && bus.fu_ready_i))
                    && tag_free && (quiet_q == '0) && !flush_i;
        end
    end

    rr_arb_ptr #(.N(NUM_REQ)) u_rr (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req       (elig),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        fu_data = '0;
        if (gnt_valid) begin
            fu_data          = bus.req_data_i[gnt_idx];
            fu_data.trans_id = alloc_tag;
        end
    end

    assign bus.req_ready_o = gnt;
    assign bus.fu_valid_o  = gnt_valid;
    assign bus.fu_data_o   = fu_data;

    // Result routing; a flush in the same cycle kills the result.
    assign res_entry = table_q[bus.fu_res_tag_i];
    assign res_hit   = bus.fu_res_valid_i && res_entry.valid && !flush_i;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            bus.rsp_valid_o[i] = res_hit && (res_entry.owner == 2'(i));
        bus.rsp_trans_id_o = res_hit ? res_entry.orig_id : '0;
        bus.rsp_result_o   = res_hit ? bus.fu_result_i : '0;
        bus.busy_o         = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            bus.busy_o = bus.busy_o | table_q[i].valid;
    end

    assign bus.dbg_bad_tag_o = bad_tag_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
            quiet_q   <= '0;
            bad_tag_q <= 1'b0;
        end else begin
            if (bus.fu_res_valid_i && !res_entry.valid) bad_tag_q <= 1'b1;
            if (flush_i) begin
                for (int i = 0; i < DEPTH; i++) table_q[i].valid <= 1'b0;
                quiet_q <= QW'(QUIET_CYCLES);
            end else begin
                if (quiet_q != '0) quiet_q <= quiet_q - 1'b1;
                if (res_hit) table_q[bus.fu_res_tag_i].valid <= 1'b0;
                // alloc_tag is a free entry, so it never collides with res_hit's tag
                if (gnt_valid) begin
                    table_q[alloc_tag].valid   <= 1'b1;
                    table_q[alloc_tag].owner   <= 2'(gnt_idx);
                    table_q[alloc_tag].orig_id <= bus.req_data_i[gnt_idx].trans_id;
                end
            end
        end
    end
endmodule

// File: tb/tb_muldiv_share_arb.sv
module tb_muldiv_share_arb;
    import ariane_pkg::*;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic flush_i = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk_i = ~clk_i;

    muldiv_share_arb_if #(.NUM_REQ(2), .TAG_W(3)) bus ();

    muldiv_share_arb #(.NUM_REQ(2), .TAG_W(3), .QUIET_CYCLES(2)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .bus     (bus)
    );

    typedef struct {
        logic [1:0] rv;
        fu_op       op0;
        logic [2:0] id0;
        fu_op       op1;
        logic [2:0] id1;
        logic       rdy;
        logic       res_v;
        logic [2:0] res_tag;
        logic       fl;
        logic [1:0] e_rdy;
        logic [2:0] e_tag;
        logic [1:0] e_rsp;
        logic [2:0] e_rid;
        logic       e_busy;
    } vec_t;

    function automatic vec_t mk(logic [1:0] rv, fu_op op0, logic [2:0] id0, fu_op op1,
                                logic [2:0] id1, logic rdy, logic res_v, logic [2:0] res_tag,
                                logic fl, logic [1:0] e_rdy, logic [2:0] e_tag,
                                logic [1:0] e_rsp, logic [2:0] e_rid, logic e_busy);
        vec_t v;
        v.rv = rv; v.op0 = op0; v.id0 = id0; v.op1 = op1; v.id1 = id1; v.rdy = rdy;
        v.res_v = res_v; v.res_tag = res_tag; v.fl = fl; v.e_rdy = e_rdy; v.e_tag = e_tag;
        v.e_rsp = e_rsp; v.e_rid = e_rid; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.req_valid_i    = '0;
        bus.fu_ready_i     = 1'b0;
        bus.fu_res_valid_i = 1'b0;
        bus.fu_res_tag_i   = '0;
        bus.fu_result_i    = '0;
        flush_i            = 1'b0;
    endtask

    task automatic apply(input vec_t v, input string tg);
        fu_op exp_op;
        @(posedge clk_i); #1;
        bus.req_valid_i              = v.rv;
        bus.req_data_i[0].operator   = v.op0;
        bus.req_data_i[0].operand_a  = 64'hA000;
        bus.req_data_i[0].operand_b  = 64'hB000;
        bus.req_data_i[0].trans_id   = v.id0;
        bus.req_data_i[1].operator   = v.op1;
        bus.req_data_i[1].operand_a  = 64'hA001;
        bus.req_data_i[1].operand_b  = 64'hB001;
        bus.req_data_i[1].trans_id   = v.id1;
        bus.fu_ready_i               = v.rdy;
        bus.fu_res_valid_i           = v.res_v;
        bus.fu_res_tag_i             = v.res_tag;
        bus.fu_result_i              = 64'hD00 + 64'(v.res_tag);
        flush_i                      = v.fl;
        @(negedge clk_i);
        chk({tg, ".req_ready"}, 64'(bus.req_ready_o), 64'(v.e_rdy));
        chk({tg, ".fu_valid"}, 64'(bus.fu_valid_o), 64'(|v.e_rdy));
        chk({tg, ".rsp_valid"}, 64'(bus.rsp_valid_o), 64'(v.e_rsp));
        chk({tg, ".busy"}, 64'(bus.busy_o), 64'(v.e_busy));
        if (|v.e_rdy) begin
            exp_op = v.e_rdy[1] ? v.op1 : v.op0;
            chk({tg, ".tag"}, 64'(bus.fu_data_o.trans_id), 64'(v.e_tag));
            chk({tg, ".op"}, 64'(bus.fu_data_o.operator), 64'(exp_op));
            chk({tg, ".opa"}, bus.fu_data_o.operand_a, v.e_rdy[1] ? 64'hA001 : 64'hA000);
        end
        if (|v.e_rsp) begin
            chk({tg, ".rsp_id"}, 64'(bus.rsp_trans_id_o), 64'(v.e_rid));
            chk({tg, ".rsp_res"}, bus.rsp_result_o, 64'hD00 + 64'(v.res_tag));
        end
    endtask

    vec_t vecs[$];

    initial begin
        bus.req_data_i = '0;
        idle();
        // rv, op0,id0, op1,id1, rdy, res_v,tag, fl,  e_rdy,e_tag, e_rsp,e_rid, e_busy
        vecs.push_back(mk(2'b00, MUL,0, MUL,0, 1, 0,0, 0, 2'b00,0, 2'b00,0, 0)); // reset state
        vecs.push_back(mk(2'b01, MUL,5, MUL,0, 1, 0,0, 0, 2'b01,0, 2'b00,0, 0)); // single MUL
        vecs.push_back(mk(2'b00, MUL,0, MUL,0, 1, 1,0, 0, 2'b00,0, 2'b01,5, 1));
        vecs.push_back(mk(2'b00, MUL,0, MUL,0, 1, 0,0, 0, 2'b00,0, 2'b00,0, 0));
        vecs.push_back(mk(2'b11, MUL,1, MUL,4, 1, 0,0, 0, 2'b10,0, 2'b00,0, 0)); // ptr at 1
        vecs.push_back(mk(2'b11, MULH,2, MULHU,5, 1, 0,0, 0, 2'b01,1, 2'b00,0, 1));
        vecs.push_back(mk(2'b11, MULHSU,3, MULW,6, 1, 0,0, 0, 2'b10,2, 2'b00,0, 1));
        vecs.push_back(mk(2'b11, MUL,7, MULH,0, 1, 0,0, 0, 2'b01,3, 2'b00,0, 1));
        vecs.push_back(mk(2'b00, MUL,0, MUL,0, 1, 1,2, 0, 2'b00,0, 2'b10,6, 1)); // OoO results
        vecs.push_back(mk(2'b00, MUL,0, MUL,0, 1, 1,1, 0, 2'b00,0, 2'b01,2, 1));
        vecs.push_back(mk(2'b00, MUL,0, MUL,0, 1, 1,3, 0, 2'b00,0, 2'b01,7, 1));
        vecs.push_back(mk(2'b00, MUL,0, MUL,0, 1, 1,0, 0, 2'b00,0, 2'b10,4, 1));
        vecs.push_back(mk(2'b00, MUL,0, MUL,0, 1, 0,0, 0, 2'b00,0, 2'b00,0, 0));
        vecs.push_back(mk(2'b10, MUL,0, MUL,3, 1, 0,0, 0, 2'b10,0, 2'b00,0, 0)); // ptr -> 0
        vecs.push_back(mk(2'b11, DIV,1, MUL,2, 0, 0,0, 0, 2'b10,1, 2'b00,0, 1)); // div gated
        vecs.push_back(mk(2'b01, DIV,1, MUL,0, 1, 0,0, 0, 2'b01,2, 2'b00,0, 1));
        vecs.push_back(mk(2'b00, MUL,0, MUL,0, 1, 1,1, 0, 2'b00,0, 2'b10,2, 1)); // MUL first
        vecs.push_back(mk(2'b00, MUL,0, MUL,0, 1, 1,2, 0, 2'b00,0, 2'b01,1, 1)); // then DIV
        vecs.push_back(mk(2'b00, MUL,0, MUL,0, 1, 1,0, 0, 2'b00,0, 2'b10,3, 1));
        vecs.push_back(mk(2'b01, ADD,4, MUL,0, 1, 0,0, 0, 2'b00,0, 2'b00,0, 0)); // non-muldiv
        vecs.push_back(mk(2'b10, MUL,0, REMW,6, 1, 0,0, 0, 2'b10,0, 2'b00,0, 0));
        vecs.push_back(mk(2'b01, MUL,2, MUL,0, 1, 1,0, 0, 2'b01,1, 2'b10,6, 1)); // free+alloc
        vecs.push_back(mk(2'b00, MUL,0, MUL,0, 1, 1,1, 0, 2'b00,0, 2'b01,2, 1));
        vecs.push_back(mk(2'b00, MUL,0, MUL,0, 1, 0,0, 0, 2'b00,0, 2'b00,0, 0));

        repeat (3) @(posedge clk_i);
        @(negedge clk_i) rst_ni = 1'b1;
        chk("reset.dbg", 64'(bus.dbg_bad_tag_o), 64'd0);

        foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

        // Fill the whole table; MUL issues regardless of fu_ready_i.
        for (int i = 0; i < 8; i++)
            apply(mk(2'b01, MUL,3'(i), MUL,0, 0, 0,0, 0, 2'b01,3'(i), 2'b00,0, i != 0),
                  $sformatf("fill%0d", i));
        apply(mk(2'b01, MUL,1, MUL,0, 1, 0,0, 0, 2'b00,0, 2'b00,0, 1), "full");
        apply(mk(2'b01, MUL,6, MUL,0, 1, 1,3, 0, 2'b00,0, 2'b01,3, 1), "free3");
        apply(mk(2'b01, MUL,6, MUL,0, 1, 0,0, 0, 2'b01,3, 2'b00,0, 1), "realloc3");
        apply(mk(2'b01, MUL,6, MUL,0, 1, 0,0, 0, 2'b00,0, 2'b00,0, 1), "full2");

        // Asynchronous reset mid-operation.
        @(posedge clk_i); #1;
        idle();
        rst_ni = 1'b0;
        #1;
        chk("arst.busy", 64'(bus.busy_o), 64'd0);
        chk("arst.fu_valid", 64'(bus.fu_valid_o), 64'd0);
        chk("arst.rsp", 64'(bus.rsp_valid_o), 64'd0);
        @(negedge clk_i) rst_ni = 1'b1;

        // Flush with three entries live.
        apply(mk(2'b01, MUL,1, MUL,0, 1, 0,0, 0, 2'b01,0, 2'b00,0, 0), "pre0");
        apply(mk(2'b01, MUL,2, MUL,0, 1, 0,0, 0, 2'b01,1, 2'b00,0, 1), "pre1");
        apply(mk(2'b01, MUL,3, MUL,0, 1, 0,0, 0, 2'b01,2, 2'b00,0, 1), "pre2");
        apply(mk(2'b11, MUL,4, MUL,5, 1, 1,1, 1, 2'b00,0, 2'b00,0, 1), "flush");
        apply(mk(2'b11, MUL,4, MUL,5, 1, 1,1, 0, 2'b00,0, 2'b00,0, 0), "quiet1");
        chk("quiet1.dbg", 64'(bus.dbg_bad_tag_o), 64'd0);
        apply(mk(2'b11, MUL,4, MUL,5, 1, 0,0, 0, 2'b00,0, 2'b00,0, 0), "quiet2");
        chk("quiet2.dbg", 64'(bus.dbg_bad_tag_o), 64'd1);
        apply(mk(2'b11, MUL,4, MUL,5, 1, 0,0, 0, 2'b10,0, 2'b00,0, 0), "post");

        @(posedge clk_i); #1;
        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
